rr_mux_arbiter: RTL and testbench

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

---
 rtl/otter_mux_pkg.sv | 17 +
 rtl/rr_mux_arbiter_if.sv | 32 +++
 rtl/rr_arbiter.sv | 37 +++
 rtl/rr_mux_arbiter.sv | 96 +++++++++
 tb/tb_rr_mux_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/otter_mux_pkg.sv
// rtl/otter_mux_pkg.sv - shared mode and state enums for the channel mux arbiter
// Purpose : common types imported by the arbiter top and its sub-modules.
// Contents: mode_e  (MODE_FIXED, MODE_RR) select policy
//           state_e (EMPTY, FULL) output register occupancy
package otter_mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// rtl/rr_mux_arbiter_if.sv - handshake bundle between channel sources, the arbiter and the sink
// Purpose : groups the N input channels and the single registered output.
// Signals : in_data[N*WIDTH] / in_valid[N] / in_ready[N]  input channels
//           sel                                           fixed-mode channel select
//           out_data / out_chan / out_valid / out_ready   registered output
// Modports: slave  - arbiter side
//           master - environment side (sources + sink)
interface rr_mux_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4
);
  localparam int IW = $clog2(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [IW-1:0]      sel;
  logic [WIDTH-1:0]   out_data;
  logic [IW-1:0]      out_chan;
  logic               out_valid;
  logic               out_ready;

  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );

  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - rotating-priority search over a request vector
// Purpose : returns the first requesting index at or after ptr, wrapping modulo N.
// Ports   : req[N]       request vector
//           ptr          highest-priority index this cycle (must be < N)
//           grant        index of the winning request
//           grant_valid  at least one request was present
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          grant_valid
);

  int idx;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    // Walk offsets 0..N-1 from ptr; N need not be a power of two, so the
    // wrap is an explicit subtract rather than a bit truncation.
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant       = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - N-to-1 channel mux with one registered output stage
// Purpose : selects one input channel per cycle (fixed SEL or round-robin) and
//           holds the chosen word in a single EMPTY/FULL output register.
// Ports   : clk  sole clock, rising edge
//           rst  asynchronous active-high reset
//           bus  rr_mux_arbiter_if.slave (channel inputs, select, output)
module rr_mux_arbiter import otter_mux_pkg::*; #(
  parameter int    WIDTH = 32,
  parameter int    N     = 4,
  parameter mode_e MODE  = MODE_RR
) (
  input  logic               clk,
  input  logic               rst,
  rr_mux_arbiter_if.slave    bus
);

  localparam int IW = $clog2(N);

  state_e        state;
  state_e        state_next;
  logic [IW-1:0] ptr;
  logic [IW-1:0] rr_grant;
  logic          rr_grant_valid;
  logic [IW-1:0] grant;
  logic          grant_valid;
  logic          load_en;
  logic          xfer;

  rr_arbiter #(.N(N)) u_rr_arbiter (
    .req         (bus.in_valid),
    .ptr         (ptr),
    .grant       (rr_grant),
    .grant_valid (rr_grant_valid)
  );

  // Grant selection and input handshake; in_data never feeds this path.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    if (MODE == MODE_FIXED) begin
      grant = bus.sel;
      // An out-of-range select (possible when N is not a power of two) grants nothing.
      if (int'(bus.sel) < N) begin
        grant_valid = bus.in_valid[bus.sel];
      end
    end else begin
      grant       = rr_grant;
      grant_valid = rr_grant_valid;
    end

    load_en = (state == EMPTY) || bus.out_ready;
    xfer    = load_en && grant_valid && !rst;

    bus.in_ready = '0;
    for (int i = 0; i < N; i++) begin
      bus.in_ready[i] = xfer && (grant == IW'(i));
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (xfer) state_next = FULL;
      FULL: begin
        // A drain and a load in the same cycle keeps the stage FULL.
        if (xfer) begin
          state_next = FULL;
        end else if (bus.out_ready) begin
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  assign bus.out_valid = (state == FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= EMPTY;
      ptr          <= '0;
      bus.out_data <= '0;
      bus.out_chan <= '0;
    end else begin
      state <= state_next;
      if (xfer) begin
        bus.out_data <= bus.in_data[int'(grant)*WIDTH +: WIDTH];
        bus.out_chan <= grant;
        if (MODE == MODE_RR) begin
          ptr <= (int'(grant) == N - 1) ? '0 : grant + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - scoreboard bench for round-robin (N=4) and fixed (N=3) arbiters
module tb_rr_mux_arbiter;
  import otter_mux_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_mux_arbiter_if #(.WIDTH(32), .N(4)) bus4 ();
  rr_mux_arbiter_if #(.WIDTH(32), .N(3)) bus3 ();

  rr_mux_arbiter #(.WIDTH(32), .N(4), .MODE(MODE_RR)) u_rr (
    .clk (clk), .rst (rst), .bus (bus4.slave)
  );
  rr_mux_arbiter #(.WIDTH(32), .N(3), .MODE(MODE_FIXED)) u_fx (
    .clk (clk), .rst (rst), .bus (bus3.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [33:0] q4[$];
  logic [33:0] q3[$];
  logic        m4_full = 1'b0;
  logic        m3_full = 1'b0;
  int          m4_ptr  = 0;
  int          wait4[4] = '{0, 0, 0, 0};
  int          max_wait = 0;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m4_full = 1'b0; m3_full = 1'b0; m4_ptr = 0;
    q4.delete(); q3.delete();
    for (int i = 0; i < 4; i++) wait4[i] = 0;
  endtask

  // One clock of the round-robin DUT: called at the falling edge, returns at the next one.
  task automatic cyc4(input logic [3:0] v, input logic ordy);
    int g; logic acc; logic [3:0] exp_rdy; logic [33:0] exp_w; logic [33:0] got_w;
    bus4.in_valid = v; bus4.out_ready = ordy;
    #1;
    g = rr_pick(v, m4_ptr);
    acc = (!m4_full || ordy) && (g >= 0);
    exp_rdy = acc ? (4'b0001 << g) : 4'b0000;
    checks++;
    if (bus4.in_ready !== exp_rdy)
      $display("FAIL rr_in_ready: got %b expected %b", bus4.in_ready, exp_rdy);
    if (bus4.in_ready !== exp_rdy) errors++;
    checks++;
    if (bus4.out_valid !== m4_full) begin
      errors++;
      $display("FAIL rr_out_valid: got %b expected %b", bus4.out_valid, m4_full);
    end
    if (m4_full && ordy) begin
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL rr_scoreboard: got output word expected empty queue");
      end else begin
        exp_w = q4.pop_front();
        got_w = {bus4.out_chan, bus4.out_data};
        if (got_w !== exp_w) begin
          errors++;
          $display("FAIL rr_out_word: got %h expected %h", got_w, exp_w);
        end
      end
    end
    if (bus4.in_ready != 4'b0000) begin
      for (int i = 0; i < 4; i++) begin
        if (!v[i] || bus4.in_ready[i]) wait4[i] = 0;
        else wait4[i]++;
        if (wait4[i] > max_wait) max_wait = wait4[i];
      end
    end
    if (acc) begin
      q4.push_back({g[1:0], bus4.in_data[g*32 +: 32]});
      m4_ptr = (g + 1) % 4;
    end
    m4_full = acc ? 1'b1 : (ordy ? 1'b0 : m4_full);
    @(negedge clk);
  endtask

  task automatic cyc3(input logic [2:0] v, input logic [1:0] s, input logic ordy);
    int g; logic acc; logic [2:0] exp_rdy; logic [33:0] exp_w; logic [33:0] got_w;
    bus3.in_valid = v; bus3.sel = s; bus3.out_ready = ordy;
    #1;
    g = int'(s);
    acc = (!m3_full || ordy) && (g < 3) && v[s];
    exp_rdy = acc ? (3'b001 << g) : 3'b000;
    checks++;
    if (bus3.in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL fx_in_ready: got %b expected %b", bus3.in_ready, exp_rdy);
    end
    checks++;
    if (bus3.out_valid !== m3_full) begin
      errors++;
      $display("FAIL fx_out_valid: got %b expected %b", bus3.out_valid, m3_full);
    end
    if (m3_full && ordy) begin
      checks++;
      if (q3.size() == 0) begin
        errors++;
        $display("FAIL fx_scoreboard: got output word expected empty queue");
      end else begin
        exp_w = q3.pop_front();
        got_w = {bus3.out_chan, bus3.out_data};
        if (got_w !== exp_w) begin
          errors++;
          $display("FAIL fx_out_word: got %h expected %h", got_w, exp_w);
        end
      end
    end
    if (acc) q3.push_back({s, bus3.in_data[g*32 +: 32]});
    m3_full = acc ? 1'b1 : (ordy ? 1'b0 : m3_full);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus4.in_valid = 4'b1111; bus4.out_ready = 1'b1; bus4.sel = '0;
    bus3.in_valid = 3'b111;  bus3.out_ready = 1'b1; bus3.sel = 2'd0;
    bus4.in_data = {32'h1003, 32'h1002, 32'h1001, 32'h1000};
    bus3.in_data = {32'h3002, 32'h3001, 32'h3000};
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus4.out_valid, bus4.out_data, bus4.out_chan} !== 35'd0) begin
      errors++;
      $display("FAIL reset_rr_out: got %h expected 0", {bus4.out_valid, bus4.out_data, bus4.out_chan});
    end
    checks++;
    if ({bus3.out_valid, bus3.out_data, bus3.out_chan} !== 35'd0) begin
      errors++;
      $display("FAIL reset_fx_out: got %h expected 0", {bus3.out_valid, bus3.out_data, bus3.out_chan});
    end
    checks++;
    if ({bus4.in_ready, bus3.in_ready} !== 7'd0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 0", {bus4.in_ready, bus3.in_ready});
    end
    bus4.in_valid = '0; bus3.in_valid = '0;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_rr_all();
    bus4.in_data = {32'h1003, 32'h1002, 32'h1001, 32'h1000};
    repeat (10) cyc4(4'b1111, 1'b1);
    repeat (2) cyc4(4'b0000, 1'b1);
  endtask

  task automatic test_rr_alternate();
    repeat (8) cyc4(4'b1010, 1'b1);
    repeat (2) cyc4(4'b0000, 1'b1);
  endtask

  task automatic test_backpressure();
    bus4.in_data = {32'hAAAA_0004, 32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001};
    cyc4(4'b0001, 1'b1);
    bus4.in_data[31:0] = 32'hAAAA_0005;
    for (int c = 0; c < 5; c++) begin
      cyc4(4'b0001, 1'b0);
      checks++;
      if (bus4.out_data !== 32'hAAAA_0001) begin
        errors++;
        $display("FAIL bp_hold_data: got %h expected aaaa0001", bus4.out_data);
      end
    end
    cyc4(4'b0001, 1'b1);
    checks++;
    if (bus4.out_data !== 32'hAAAA_0005) begin
      errors++;
      $display("FAIL bp_reload: got %h expected aaaa0005", bus4.out_data);
    end
    repeat (2) cyc4(4'b0000, 1'b1);
  endtask

  task automatic test_fixed();
    bus3.in_data = {32'h3002, 32'h3001, 32'h3000};
    repeat (4) cyc3(3'b111, 2'd2, 1'b1);
    repeat (3) cyc3(3'b111, 2'd3, 1'b1);
    checks++;
    if (bus3.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL fx_sel_oob_drain: got %b expected 0", bus3.out_valid);
    end
  endtask

  task automatic test_async_reset();
    bus4.in_data = {32'h5003, 32'h5002, 32'h5001, 32'h5000};
    cyc4(4'b0100, 1'b1);
    cyc4(4'b1111, 1'b0);
    bus4.in_valid = 4'b1111;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus4.out_valid, bus4.out_data, bus4.out_chan, bus4.in_ready} !== 39'd0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0", {bus4.out_valid, bus4.out_data, bus4.out_chan, bus4.in_ready});
    end
    model_reset();
    bus4.in_valid = 4'b0000;
    #1 rst = 1'b0;
    @(negedge clk);
    cyc4(4'b1111, 1'b1);
    checks++;
    if (bus4.out_chan !== 2'd0) begin
      errors++;
      $display("FAIL post_reset_grant: got %0d expected 0", bus4.out_chan);
    end
    repeat (2) cyc4(4'b0000, 1'b1);
  endtask

  task automatic test_random();
    for (int c = 0; c < 5000; c++) begin
      bus4.in_data = {$urandom, $urandom, $urandom, $urandom};
      cyc4(4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
    end
    repeat (2) cyc4(4'b0000, 1'b1);
    for (int c = 0; c < 5000; c++) begin
      bus3.in_data = {$urandom, $urandom, $urandom};
      cyc3(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
    end
    repeat (2) cyc3(3'b000, 2'd0, 1'b1);
    checks++;
    if (q4.size() + q3.size() != 0) begin
      errors++;
      $display("FAIL rand_dropped: got %0d pending expected 0", q4.size() + q3.size());
    end
    checks++;
    if (max_wait > 3) begin
      errors++;
      $display("FAIL rr_starvation: got %0d expected <= 3", max_wait);
    end
  endtask

  initial begin
    test_reset();
    test_rr_all();
    test_rr_alternate();
    test_backpressure();
    test_fixed();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
